// File: rtl/fmap_stream_writer.sv
// rtl/fmap_stream_writer.sv - requantising feature-map stream capture buffer with registered readback
module fmap_stream_writer #(
  parameter int WIDTH   = 32,
  parameter int HEIGHT  = 32,
  parameter int FILTERS = 16,
  parameter int SHIFT   = 8,
  parameter int RELU    = 1,
  localparam int PIXELS = WIDTH * HEIGHT,
  localparam int DEPTH  = PIXELS * FILTERS,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int FW     = (FILTERS > 1) ? $clog2(FILTERS) : 1,
  localparam int PW     = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [FW-1:0] filter_idx
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic signed [32:0] ROUND = 33'sd1 <<< (SHIFT - 1);
  localparam logic [AW:0]        DEPTH_EXT = (AW + 1)'(DEPTH);

  logic [1:0]     r_state;
  logic [PW-1:0]  r_pixel;
  logic [FW-1:0]  r_filter;
  logic [AW-1:0]  r_wr_addr;
  logic           r_overflow;
  logic [7:0]     r_rd_data;
  logic [7:0]     r_mem [DEPTH];

  logic signed [32:0] w_sum;
  logic signed [32:0] w_shr;
  logic [7:0]         w_q;
  logic               w_we;
  logic               w_last_pix;
  logic               w_last_filt;

  // Round-half-up, arithmetic shift in 33 bits so the rounding add cannot wrap
  assign w_sum = $signed({in_data[31], in_data}) + ROUND;
  assign w_shr = w_sum >>> SHIFT;

  // Optional ReLU, then saturate into a signed byte
  always_comb begin
    w_q = w_shr[7:0];
    if ((RELU != 0) && in_data[31]) begin
      w_q = 8'h00;
    end else if (w_shr > 33'sd127) begin
      w_q = 8'h7F;
    end else if (w_shr < -33'sd128) begin
      w_q = 8'h80;
    end
  end

  // A sample coinciding with start is dropped; reset blocks writes entirely
  assign w_we        = rst && !start && in_valid && (r_state == S_CAPTURE);
  assign w_last_pix  = (r_pixel == PW'(PIXELS - 1));
  assign w_last_filt = (r_filter == FW'(FILTERS - 1));

  // Frame sequencing: counters, state and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pixel    <= '0;
      r_filter   <= '0;
      r_wr_addr  <= '0;
      r_overflow <= 1'b0;
    end else if (start) begin
      r_state    <= S_CAPTURE;
      r_pixel    <= '0;
      r_filter   <= '0;
      r_wr_addr  <= '0;
      r_overflow <= 1'b0;
    end else if (in_valid) begin
      if (r_state == S_CAPTURE) begin
        r_wr_addr <= r_wr_addr + AW'(1);
        if (w_last_pix) begin
          r_pixel <= '0;
          if (w_last_filt) begin
            r_filter  <= '0;
            r_wr_addr <= '0;
            r_state   <= S_DONE;
          end else begin
            r_filter <= r_filter + FW'(1);
          end
        end else begin
          r_pixel <= r_pixel + PW'(1);
        end
      end else begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Frame storage write port; memory survives reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_addr] <= w_q;
    end
  end

  // Registered read-first port; out-of-range addresses hold the last value
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data <= 8'h00;
    end else if ({1'b0, rd_addr} < DEPTH_EXT) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data    = r_rd_data;
  assign busy       = (r_state == S_CAPTURE);
  assign done       = (r_state == S_DONE);
  assign overflow   = r_overflow;
  assign filter_idx = r_filter;

endmodule

// File: doc/fmap_stream_writer.md
FMAP_STREAM_WRITER -- requirements
Module: fmap_stream_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, feature-map columns.
REQ-002 SHALL have parameter HEIGHT, default 32, feature-map rows.
REQ-003 SHALL have parameter FILTERS, default 16, number of feature maps per frame.
REQ-004 SHALL have parameter SHIFT, default 8, requantisation right-shift (1..16).
REQ-005 SHALL have parameter RELU, default 1, 1 = clamp negatives to 0 before storing.
REQ-006 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle pulse, arms capture of a new frame.
REQ-009 SHALL have port in_valid  input  1  stream sample strobe from conv stage (no backpressure).
REQ-010 SHALL have port in_data  input  32  signed accumulator sample, raster order, filter-major.
REQ-011 SHALL have port rd_addr  input  clog2(WIDTH*HEIGHT*FILTERS)  read address for next layer (14 bits at defaults).
REQ-012 SHALL have port rd_data  output  8  signed stored byte, registered.
REQ-013 SHALL have port busy  output  1  high while in CAPTURE.
REQ-014 SHALL have port done  output  1  high in DONE state, held until next start.
REQ-015 SHALL have port overflow  output  1  sticky flag, sample received outside CAPTURE.
REQ-016 SHALL have port filter_idx  output  clog2(FILTERS)  current filter being written.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, DONE; exactly one active.
REQ-018 SHALL go IDLE->CAPTURE on start=1, clearing pixel counter, filter_idx, overflow.
REQ-019 SHALL, in CAPTURE, write one byte per in_valid=1 cycle to address filter_idx*WIDTH*HEIGHT + pixel; write commits same edge.
REQ-020 SHALL requantise: r = (in_data + 2^(SHIFT-1)) >>> SHIFT (arithmetic, 32-bit signed, wrap-free); if RELU and in_data<0 then 0; saturate to [-128,127].
REQ-021 SHALL increment pixel per accepted sample; at pixel = WIDTH*HEIGHT-1 wrap pixel to 0 and increment filter_idx.
REQ-022 SHALL go CAPTURE->DONE on the write of pixel WIDTH*HEIGHT-1 of filter FILTERS-1; done=1, busy=0 from the following cycle.
REQ-023 SHALL go DONE->CAPTURE on start=1 (new frame, counters cleared, old contents overwritten progressively).
REQ-024 SHALL treat start=1 during CAPTURE as restart: counters cleared, state stays CAPTURE.
REQ-025 SHALL, when start=1 and in_valid=1 coincide, honour start and drop that sample (no write).
REQ-026 SHALL ignore in_valid in IDLE/DONE (no write, counters frozen) and set overflow=1 until next start or reset.
REQ-027 SHALL tolerate in_valid gaps of any length in CAPTURE with no state change.
REQ-028 SHALL present rd_data = mem[rd_addr] one cycle after rd_addr is sampled, in every state.
REQ-029 SHALL return old data when rd_addr equals the address written in the same cycle (read-first).
REQ-030 SHALL return rd_data of unspecified but stable value for rd_addr >= WIDTH*HEIGHT*FILTERS.

Reset
REQ-031 SHALL, on rst=0 at a clock edge, enter IDLE with busy=0, done=0, overflow=0, filter_idx=0, pixel=0, rd_data=0.
REQ-032 SHALL abort a capture in progress on reset without clearing memory contents.
REQ-033 SHALL ignore start and in_valid (no overflow set) while rst=0.

Verification
REQ-034 SHALL verify full frame: start, 16384 samples in_data=k*256 (k=0..16383, mod 2^31) with random gaps -> done=1 one cycle after last sample; readback addr a gives sat(a) per REQ-020 (addr 5 -> 5, addr 200 -> 127).
REQ-035 SHALL verify requant: in_data=383 -> 1 (rounds 1.496 down), 384 -> 2, -500 with RELU=1 -> 0, -500 with RELU=0 -> -2, 0x7FFF0000 -> 127.
REQ-036 SHALL verify boundary: sample 1024 lands at addr 1024 with filter_idx=1 after the 1024th accept; sample 16383 lands at addr 16383.
REQ-037 SHALL verify overflow: in_valid=1 in DONE -> overflow=1, memory unchanged; next start -> overflow=0.
REQ-038 SHALL verify start with in_valid same cycle mid-frame -> sample dropped, next sample written at addr 0, filter_idx=0.
REQ-039 SHALL verify reset mid-capture at pixel 300 -> IDLE, busy=0, done=0; previously written addrs 0..299 still read back correctly.
